muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M/RV64M multiply/divide unit that sits beside the ALU in the execute stage. It accepts already-forwarded operands, computes one result bit per cycle, and raises a stall request so the hazard unit freezes IF/ID/EX until the result is ready. The result then joins the ALU result path into the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; legal values are even and >= 8
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  launch op; sampled only in IDLE
funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a_i  input  XLEN  rs1 value after forwarding
operand_b_i  input  XLEN  rs2 value after forwarding
flush_i  input  1  abort the in-flight op (branch mispredict / trap)
stall_o  output  1  hazard-unit stall request
busy_o  output  1  registered; high in BUSY
done_o  output  1  one-cycle result-valid pulse
result_o  output  XLEN  result; valid while done_o is high, held until the next accepted start

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0, all internal regs=0. Reset asserted mid-operation discards the op with no done_o.
- FSM states:
  - IDLE: start_i=1 latches funct3, operands and operand signs, then goes to BUSY with counter=XLEN.
  - IDLE special case, divide op with operand_b=0: go to DONE directly.
  - IDLE special case, signed DIV/REM with a=most-negative and b=-1: go to DONE directly.
  - BUSY: one iteration per cycle, counter decrements; when counter reaches 1, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency:
  - Normal op: start accepted at edge N, done_o high in cycle N+XLEN (XLEN+1 cycles including the start cycle).
  - Special-case divide: done_o high in the cycle after the start cycle.
- stall_o is combinational: (IDLE && start_i) || BUSY. It is low in DONE so the pipeline advances while the result is captured.
- start_i in BUSY or DONE is ignored. The hazard unit guarantees it only re-presents the instruction while stalled.
- flush_i in any state forces IDLE next cycle with no done_o. result_o keeps its old value. flush_i wins over a simultaneous start_i.
- Multiply: unsigned shift-add on magnitudes giving a 2*XLEN product.
  - Negate the product when the effective operand signs differ.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
- Divide: restoring radix-2 division on magnitudes.
  - Quotient sign = sign_a XOR sign_b (signed ops only); remainder sign = sign_a. Truncation is toward zero.
  - Divide by zero: quotient = all ones; remainder = operand_a.
  - Signed overflow (most-negative / -1): quotient = operand_a; remainder = 0.
- All arithmetic is modulo the stated widths; no exceptions are raised.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (XLEN=32) -> stall_o high for 32 cycles, done_o pulse at cycle 32 after start, result_o=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> done_o in the cycle after start, result 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start DIVU, assert flush_i at cycle 10 together with start_i -> IDLE next cycle, no done_o, result_o unchanged. A following MUL 3*4 -> 12 with full latency.
- Drop rst_n asynchronously mid-BUSY (between clock edges) -> busy_o/stall_o low immediately, no done_o. Repeat with XLEN=64: MUL 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001 after 64 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit, one result bit per cycle
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_d;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              is_div, a_signed, b_signed, sign_a, sign_b;
    logic              div_zero, div_ovf, special, launch, last_iter;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;

    // Operand decode at launch; MUL uses signed decode since its low half is sign-agnostic
    assign is_div      = funct3_i[2];
    assign a_signed    = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    assign b_signed    = is_div ? ~funct3_i[0] : ~funct3_i[1];
    assign sign_a      = a_signed & operand_a_i[XLEN-1];
    assign sign_b      = b_signed & operand_b_i[XLEN-1];
    assign mag_a       = sign_a ? -operand_a_i : operand_a_i;
    assign mag_b       = sign_b ? -operand_b_i : operand_b_i;
    assign div_zero    = is_div & (operand_b_i == '0);
    assign div_ovf     = is_div & ~funct3_i[0] & (operand_a_i == MIN_NEG) & (operand_b_i == '1);
    assign special     = div_zero | div_ovf;
    assign special_res = div_zero ? (funct3_i[1] ? operand_a_i : '1)
                                  : (funct3_i[1] ? '0 : operand_a_i);
    assign launch      = (state == IDLE) & start_i & ~flush_i;
    assign last_iter   = (cnt_q == CNT_W'(1));

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign acc_next  = op_q[2] ? div_next : mul_next;

    assign prod = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
    assign quo  = (neg_a_q ^ neg_b_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    assign rem  = neg_a_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        if (op_q[2])
            final_res = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00)
            final_res = prod[XLEN-1:0];
        else
            final_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        stall_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state)
            IDLE: begin
                stall_o = start_i;
                if (start_i && !flush_i)
                    state_d = special ? DONE : BUSY;
            end
            BUSY: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                if (flush_i)
                    state_d = IDLE;
                else if (last_iter)
                    state_d = DONE;
            end
            DONE: begin
                done_o  = ~flush_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_o <= '0;
        end else if (launch) begin
            op_q    <= funct3_i;
            neg_a_q <= sign_a;
            neg_b_q <= sign_b;
            acc_q   <= {{XLEN{1'b0}}, mag_a};
            opb_q   <= mag_b;
            cnt_q   <= CNT_W'(XLEN);
            if (special)
                result_o <= special_res;
        end else if (state == BUSY && !flush_i) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_iter)
                result_o <= final_res;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit at XLEN=32 and XLEN=64
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, flush32 = 1'b0;
    logic [2:0]  f3_32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        stall32, busy32, done32;
    logic [31:0] r32;

    logic        start64 = 1'b0, flush64 = 1'b0;
    logic [2:0]  f3_64 = '0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        stall64, busy64, done64;
    logic [63:0] r64;

    int checks = 0;
    int fails  = 0;
    int done_seen;

    logic [2:0]  rf3;
    logic [63:0] ra, rb, rmask, rmin;
    int          rmode;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start_i(start32), .funct3_i(f3_32),
        .operand_a_i(a32), .operand_b_i(b32), .flush_i(flush32),
        .stall_o(stall32), .busy_o(busy32), .done_o(done32), .result_o(r32)
    );

    muldiv_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start_i(start64), .funct3_i(f3_64),
        .operand_a_i(a64), .operand_b_i(b64), .flush_i(flush64),
        .stall_o(stall64), .busy_o(busy64), .done_o(done64), .result_o(r64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: wide signed integer arithmetic, RISC-V divide-by-zero rule applied explicitly
    function automatic logic [63:0] model(input int xlen, input logic [2:0] f3,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0]        mask, a, b;
        logic signed [129:0] A, B, R;
        bit                 sa, sb;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xlen) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        case (f3)
            3'b000, 3'b001, 3'b100, 3'b110: begin sa = 1'b1; sb = 1'b1; end
            3'b010:                         begin sa = 1'b1; sb = 1'b0; end
            default:                        begin sa = 1'b0; sb = 1'b0; end
        endcase
        A = $signed({66'd0, a});
        B = $signed({66'd0, b});
        if (sa && a[xlen-1]) A = A - (130'sd1 <<< xlen);
        if (sb && b[xlen-1]) B = B - (130'sd1 <<< xlen);
        if (!f3[2]) begin
            R = A * B;
            if (f3[1:0] != 2'b00) R = R >>> xlen;
        end else if (B == 0) begin
            R = f3[1] ? A : -130'sd1;
        end else begin
            R = f3[1] ? (A % B) : (A / B);
        end
        return R[63:0] & mask;
    endfunction

    task automatic run_op(input bit w64, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input string tag);
        int          xl, lat, n, stl;
        bit          special;
        logic [63:0] mask, minv;
        xl   = w64 ? 64 : 32;
        mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        minv = 64'd1 << (xl - 1);
        special = f3[2] && (((b & mask) == 0) || (!f3[0] && (a & mask) == minv && (b & mask) == mask));
        lat = special ? 0 : xl;
        @(negedge clk);
        if (w64) begin start64 = 1'b1; f3_64 = f3; a64 = a; b64 = b; end
        else     begin start32 = 1'b1; f3_32 = f3; a32 = a[31:0]; b32 = b[31:0]; end
        #1;
        check({tag, " stall_at_start"}, {63'd0, w64 ? stall64 : stall32}, 64'd1);
        @(negedge clk);
        start32 = 1'b0;
        start64 = 1'b0;
        n = 0;
        stl = 0;
        while (!(w64 ? done64 : done32) && n < 300) begin
            if (w64 ? stall64 : stall32) stl++;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " stall_cycles"}, 64'(stl), 64'(lat));
        check({tag, " result"}, w64 ? r64 : {32'd0, r32}, exp & mask);
        check({tag, " stall_in_done"}, {63'd0, w64 ? stall64 : stall32}, 64'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {63'd0, w64 ? done64 : done32}, 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset busy32", {63'd0, busy32}, 64'd0);
        check("reset done32", {63'd0, done32}, 64'd0);
        check("reset stall32", {63'd0, stall32}, 64'd0);
        check("reset result32", {32'd0, r32}, 64'd0);
        check("reset busy64", {63'd0, busy64}, 64'd0);
        check("reset result64", r64, 64'd0);
        rst_n = 1'b1;

        run_op(0, 3'b000, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, "MUL neg");
        run_op(0, 3'b001, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "MULH min");
        run_op(0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "MULHU max");
        run_op(0, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "MULHSU");
        run_op(0, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, "DIV neg");
        run_op(0, 3'b110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, "REM neg");
        run_op(0, 3'b101, 64'd100, 64'd7, 64'd14, "DIVU");
        run_op(0, 3'b111, 64'd100, 64'd7, 64'd2, "REMU");
        run_op(0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "DIV ovf");
        run_op(0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, "REM ovf");
        run_op(0, 3'b100, 64'd5, 64'd0, 64'hFFFF_FFFF, "DIV by0");
        run_op(0, 3'b110, 64'd5, 64'd0, 64'd5, "REM by0");

        // Flush a DIVU at its tenth busy cycle together with a fresh start
        @(negedge clk);
        start32 = 1'b1; f3_32 = 3'b101; a32 = 32'd1000; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        flush32 = 1'b1;
        start32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        start32 = 1'b0;
        check("flush busy", {63'd0, busy32}, 64'd0);
        check("flush done", {63'd0, done32}, 64'd0);
        check("flush result_kept", {32'd0, r32}, 64'd5);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) done_seen++;
        end
        check("flush no_done", 64'(done_seen), 64'd0);
        run_op(0, 3'b000, 64'd3, 64'd4, 64'd12, "MUL after flush");

        // Asynchronous reset between clock edges while both units are busy
        @(negedge clk);
        start32 = 1'b1; f3_32 = 3'b000; a32 = 32'd9; b32 = 32'd9;
        start64 = 1'b1; f3_64 = 3'b101; a64 = 64'd12345; b64 = 64'd7;
        @(negedge clk);
        start32 = 1'b0;
        start64 = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy32", {63'd0, busy32}, 64'd0);
        check("arst stall32", {63'd0, stall32}, 64'd0);
        check("arst busy64", {63'd0, busy64}, 64'd0);
        check("arst stall64", {63'd0, stall64}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("arst result32", {32'd0, r32}, 64'd0);
        done_seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done32 || done64) done_seen++;
        end
        check("arst no_done", 64'(done_seen), 64'd0);

        run_op(1, 3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "MUL64");
        run_op(1, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, "DIV64 ovf");
        run_op(1, 3'b111, 64'd77, 64'd0, 64'd77, "REMU64 by0");

        for (int i = 0; i < 80; i++) begin
            bit w;
            w     = (i >= 50);
            rmask = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
            rmin  = w ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            rf3   = 3'($urandom_range(0, 7));
            ra    = {$urandom, $urandom} & rmask;
            rb    = {$urandom, $urandom} & rmask;
            rmode = $urandom_range(0, 6);
            case (rmode)
                1: rb = '0;
                2: begin ra = rmin; rb = rmask; end
                3: begin ra = 64'($urandom_range(0, 40)); rb = 64'($urandom_range(0, 9)); end
                4: ra = rmin;
                5: rb = rmask - 64'($urandom_range(0, 3));
                default: ;
            endcase
            run_op(w, rf3, ra, rb, model(w ? 64 : 32, rf3, ra, rb), w ? "rand64" : "rand32");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
